fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if_id_reg.sv | 52 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : 2-bit fetch FSM encoding
//   NOP_IR_DEFAULT   : instruction word presented while the IF/ID slot is empty
//   RESET_PC_DEFAULT : first fetch address after reset
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // request outstanding, data wanted
        ST_HOLD = 2'd1,  // word buffered, waiting for the slot to free up
        ST_ADV  = 2'd2,  // slot just loaded, pc takes the predictor's nPC
        ST_DROP = 2'd3   // request outstanding, data to be thrown away
    } fetch_state_e;

    localparam logic [31:0] NOP_IR_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline slot: holds one fetched instruction and its PC.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : capture load_pc_i/load_ir_i and mark the slot live
//   clear_i     : slot consumed by ID (lower priority than load)
//   flush_i     : redirect kill (highest priority)
//   id_pc_o     : PC of the held instruction
//   id_ir_o     : held instruction, or NOP_IR whenever the slot is empty
//   id_valid_o  : slot holds a live instruction
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_IR = NOP_IR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic [31:0] load_ir_i,
    input  logic        clear_i,
    input  logic        flush_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_ir_o,
    output logic        id_valid_o
);

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        valid_q;

    // Slot storage: flush beats load, load beats consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0000_0000;
            ir_q    <= NOP_IR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= load_pc_i;
            ir_q    <= load_ir_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign id_pc_o    = pc_q;
    // Stale contents never leak to ID once the slot is empty.
    assign id_ir_o    = valid_q ? ir_q : NOP_IR;
    assign id_valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, feeding
// a single IF/ID slot, with redirect (jump_test) and ID back-pressure (stall).
//   clk, rst        : clock, asynchronous active-high reset
//   nPC             : next PC from the predictor (or redirect target)
//   jump_test       : EX redirect, overrides every other event
//   stall           : ID cannot consume the slot this cycle
//   imem_req/addr   : memory request strobe and address
//   imem_rdata/ack  : memory completion (ack may come in the request cycle)
//   ID_PC/IR/VALID  : IF/ID slot contents
//   fetch_busy      : a memory request is outstanding
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_IR   = NOP_IR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nPC,
    input  logic        jump_test,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_IR,
    output logic        ID_VALID,
    output logic        fetch_busy
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  buf_q;

    logic         slot_free;
    logic         slot_clear;
    logic         slot_load;
    logic [31:0]  slot_ir;

    // The slot can take a new word if it is empty or being consumed now.
    assign slot_free  = !ID_VALID || !stall;
    assign slot_clear = ID_VALID && !stall;

    // Slot load decision and data source (fresh memory word or buffered word).
    always_comb begin
        slot_load = 1'b0;
        slot_ir   = imem_rdata;
        if (jump_test) begin
            slot_load = 1'b0;
        end else begin
            case (state_q)
                ST_REQ:  slot_load = imem_ack && slot_free;
                ST_HOLD: begin
                    slot_load = !stall;
                    slot_ir   = buf_q;
                end
                default: slot_load = 1'b0;
            endcase
        end
    end

    // Fetch FSM with pc and holding buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
        end else if (jump_test) begin
            pc_q  <= nPC;
            buf_q <= 32'h0000_0000;
            case (state_q)
                // An unanswered request must still be drained before reissuing.
                ST_REQ:  state_q <= imem_ack ? ST_REQ : ST_DROP;
                // A drain completing this very cycle frees the port; staying
                // in DROP would wait for an ack that never comes.
                ST_DROP: state_q <= imem_ack ? ST_REQ : ST_DROP;
                default: state_q <= ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ack) begin
                        if (slot_free) begin
                            state_q <= ST_ADV;
                        end else begin
                            buf_q   <= imem_rdata;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_q <= ST_ADV;
                    end
                end
                // One bubble so the predictor sees the new ID_PC before nPC is taken.
                ST_ADV: begin
                    pc_q    <= nPC;
                    state_q <= ST_REQ;
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

    // Reset is state REQ, but no request may be presented while rst is high.
    assign imem_req   = (state_q == ST_REQ) && !rst;
    assign imem_addr  = pc_q;
    assign fetch_busy = ((state_q == ST_REQ) || (state_q == ST_DROP)) && !rst;

    if_id_reg #(
        .NOP_IR (NOP_IR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (slot_load),
        .load_pc_i  (pc_q),
        .load_ir_i  (slot_ir),
        .clear_i    (slot_clear),
        .flush_i    (jump_test),
        .id_pc_o    (ID_PC),
        .id_ir_o    (ID_IR),
        .id_valid_o (ID_VALID)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a short
// pseudo-random tail, checked every cycle against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] nPC;
    logic        jump_test;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] ID_PC;
    logic [31:0] ID_IR;
    logic        ID_VALID;
    logic        fetch_busy;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_IR   (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nPC        (nPC),
        .jump_test  (jump_test),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .ID_PC      (ID_PC),
        .ID_IR      (ID_IR),
        .ID_VALID   (ID_VALID),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // stimulus knobs
    logic        stall_v = 1'b0;
    logic        jump_v  = 1'b0;
    logic [31:0] tgt_v   = 32'h0;
    int          lat_v   = 0;
    bit          ovr_en  = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    // memory responder state
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;
    int          mem_lat  = 0;

    // behavioural model: request outstanding / to be discarded / word parked /
    // one-cycle bubble after a load, plus the slot itself
    bit          m_out, m_disc, m_bufv, m_gap, m_v;
    logic [31:0] m_pc, m_buf, m_id_pc, m_id_ir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b1; m_disc = 1'b0; m_bufv = 1'b0; m_gap = 1'b0; m_v = 1'b0;
        m_pc = RST_PC; m_buf = 32'h0; m_id_pc = 32'h0; m_id_ir = NOP;
    endtask

    // One clock edge of the fetch rules, from the inputs held during the cycle.
    task automatic model_step();
        bit loaded;
        loaded = 1'b0;
        if (rst) begin
            model_reset();
        end else if (jump_test) begin
            m_v = 1'b0; m_bufv = 1'b0; m_gap = 1'b0; m_pc = nPC;
            if (m_out && !imem_ack) m_disc = 1'b1;
            else begin m_out = 1'b1; m_disc = 1'b0; end
        end else begin
            if (m_out && imem_ack) begin
                if (m_disc) m_disc = 1'b0;
                else if (!m_v || !stall) begin
                    m_id_pc = m_pc; m_id_ir = imem_rdata; m_v = 1'b1; loaded = 1'b1;
                    m_out = 1'b0; m_gap = 1'b1;
                end else begin
                    m_buf = imem_rdata; m_bufv = 1'b1; m_out = 1'b0;
                end
            end else if (m_bufv) begin
                if (!stall) begin
                    m_id_pc = m_pc; m_id_ir = m_buf; m_v = 1'b1; loaded = 1'b1;
                    m_bufv = 1'b0; m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_pc = nPC; m_gap = 1'b0; m_out = 1'b1;
            end
            if (!loaded && m_v && !stall) m_v = 1'b0;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",   {31'd0, imem_req},   {31'd0, m_out && !m_disc && !rst});
            chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, m_out && !rst});
            chk("ID_VALID",   {31'd0, ID_VALID},   {31'd0, m_v});
            chk("ID_IR",      ID_IR,               m_v ? m_id_ir : NOP);
            if (m_out && !m_disc && !rst) chk("imem_addr", imem_addr, m_pc);
            if (m_v) chk("ID_PC", ID_PC, m_id_pc);
        end
    end

    // One cycle: drive control, then memory/predictor, then clock edge and model.
    task automatic tick();
        @(negedge clk);
        #1;
        stall     = stall_v;
        jump_test = jump_v;
        #1;
        nPC = jump_v ? tgt_v : ID_PC + 32'd4;
        if (rst) begin
            mem_pend = 1'b0; imem_ack = 1'b0;
        end else begin
            if (!mem_pend && imem_req) begin
                mem_pend = 1'b1; mem_addr = imem_addr; mem_cnt = 0; mem_lat = lat_v;
            end
            if (mem_pend && mem_cnt == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = ovr_en ? ovr_val : mem_word(mem_addr);
                mem_pend   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                if (mem_pend) mem_cnt++;
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        jump_v = 1'b1; tgt_v = a; lat_v = 0;
        tick();
        jump_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nPC = 32'h0; jump_test = 1'b0; stall = 1'b0;
        imem_rdata = 32'h0; imem_ack = 1'b0;
        model_reset();
        repeat (2) tick();
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_valid", {31'd0, ID_VALID},  32'd0);
        chk("rst_ir",    ID_IR,              NOP);

        // reset release, ack in the request cycle
        rst = 1'b0;
        #1;
        chk("c1_req",  {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr,         32'h0000_0000);
        chk_en = 1'b1;
        tick();
        chk("c2_valid", {31'd0, ID_VALID}, 32'd1);
        chk("c2_pc",    ID_PC,             32'h0000_0000);
        chk("c2_ir",    ID_IR,             32'h5A5A_0000);
        tick();
        chk("c3_addr", imem_addr, 32'h0000_0004);

        // three-cycle memory latency
        goto_pc(32'h0000_0040);
        lat_v = 3;
        chk("lat_addr0", imem_addr, 32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_addr", imem_addr,          32'h0000_0040);
            chk("lat_busy", {31'd0, fetch_busy}, 32'd1);
        end
        tick();
        chk("lat_valid", {31'd0, ID_VALID}, 32'd1);
        chk("lat_ir",    ID_IR,             32'h5A1A_0040);

        // stall: word parked while ID holds its instruction
        stall_v = 1'b1; lat_v = 0;
        tick();
        ovr_en = 1'b1; ovr_val = 32'h2000_0001;
        tick();
        ovr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_pc",  ID_PC,             32'h0000_0040);
            chk("hold_ir",  ID_IR,             32'h5A1A_0040);
            tick();
        end
        stall_v = 1'b0;
        tick();
        chk("unstall_ir", ID_IR, 32'h2000_0001);
        chk("unstall_pc", ID_PC, 32'h0000_0044);

        // redirect while a request is in flight
        goto_pc(32'h0000_0010);
        lat_v = 2;
        tick();
        jump_v = 1'b1; tgt_v = 32'h0000_0080;
        tick();
        jump_v = 1'b0;
        chk("drop_valid", {31'd0, ID_VALID},   32'd0);
        chk("drop_busy",  {31'd0, fetch_busy}, 32'd1);
        chk("drop_req",   {31'd0, imem_req},   32'd0);
        lat_v = 0;
        tick();
        chk("drop_done_req",  {31'd0, imem_req}, 32'd1);
        chk("drop_done_addr", imem_addr,         32'h0000_0080);
        tick();
        chk("redir_pc", ID_PC, 32'h0000_0080);
        chk("redir_ir", ID_IR, 32'h5ADA_0080);

        // ack and redirect in the same cycle
        goto_pc(32'h0000_0010);
        jump_v = 1'b1; tgt_v = 32'h0000_0200;
        tick();
        jump_v = 1'b0;
        chk("same_valid", {31'd0, ID_VALID}, 32'd0);
        chk("same_req",   {31'd0, imem_req}, 32'd1);
        chk("same_addr",  imem_addr,         32'h0000_0200);

        // async reset while parked in HOLD
        stall_v = 1'b1;
        repeat (3) tick();
        chk("pre_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("pre_rst_valid", {31'd0, ID_VALID}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        mem_pend = 1'b0; imem_ack = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ID_VALID},   32'd0);
        chk("arst_req",   {31'd0, imem_req},   32'd0);
        chk("arst_busy",  {31'd0, fetch_busy}, 32'd0);
        chk("arst_pc",    imem_addr,           RST_PC);
        chk("arst_ir",    ID_IR,               NOP);
        rst = 1'b0; stall_v = 1'b0; stall = 1'b0;
        @(posedge clk);
        model_step();
        #1;

        // 32-bit wrap of the sequential PC
        goto_pc(32'hFFFF_FFFC);
        tick();
        tick();
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // pseudo-random tail
        for (int i = 0; i < 80; i++) begin
            lat_v   = $urandom_range(0, 2);
            stall_v = ($urandom_range(0, 3) == 0);
            jump_v  = ($urandom_range(0, 9) == 0);
            tgt_v   = $urandom;
            tick();
        end
        jump_v = 1'b0; stall_v = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
